irq_trap_ctrl: RTL and testbench
================================

# irq_trap_ctrl

Parametrised machine-mode interrupt/trap sequencer between the MEM stage, the CSR file and the fetch redirect. It latches N interrupt sources (per-source level or edge), masks them with `mie` and `mstatus.MIE`, and selects the lowest-index request. It then stalls the pipeline while it writes `mepc`, `mstatus` and `mcause` over consecutive cycles and redirects fetch to a direct or vectored `mtvec` target. It also handles `ecall` and `mret`, including MPIE save/restore.

## Interface
- `N_IRQ`, 8: number of interrupt sources, 1..16.
- `EDGE_MASK`, {N_IRQ{1'b0}}: bit i = 1 makes source i rising-edge triggered; 0 makes it level triggered.
- `CAUSE_BASE`, 16: the mcause code for source i is `CAUSE_BASE + i`.
- `clk` in 1: the single clock; all state updates on posedge.
- `clr` in 1: synchronous, active-high reset.
- `irq_pins` in N_IRQ: raw interrupt requests.
- `ecall_MEM`, `mret_MEM` in 1: decoded ecall/mret in MEM.
- `instr_addr_MEM` in 32: PC of the MEM instruction.
- `branch_MEM` in 1: taken branch in MEM.
- `branch_addr_MEM` in 32: its target.
- `mtvec`, `mepc`, `mstatus`, `mie` in 32: current CSR values.
- `set_pl_pause` out 1: pipeline stall.
- `csr_we` out 1: CSR write strobe.
- `csr_waddr` out 12: CSR address.
- `csr_wdata` out 32: CSR write data.
- `int_flag` out 1: one-cycle fetch-redirect pulse.
- `int_addr` out 32: redirect target.
- `irq_ack` out N_IRQ: one-hot pulse for the source taken.

## Operation
- Pending, edge source i: set on a 0→1 transition of `irq_pins[i]` versus a registered sample. Held until taken (`irq_ack[i]`). An edge in the same cycle as ack re-sets it.
- Pending, level source i: `irq_pins[i]` directly; no latch.
- Eligible = pending & `mie[N_IRQ-1:0]`. An async request exists when eligible != 0 and `mstatus[3]`=1. Winner = lowest eligible index.
- Request priority in IDLE: `ecall_MEM` > `mret_MEM` > async.
- States: IDLE, MEPC, MSTATUS, MCAUSE, MRET.
- On leaving IDLE for a trap, capture `epc` and `cause` registers:
  - ecall: epc = `branch_MEM ? branch_addr_MEM-4 : instr_addr_MEM`; cause = 32'h0000000B.
  - async: epc = `branch_MEM ? branch_addr_MEM : instr_addr_MEM`; cause = {1'b1, 31'(CAUSE_BASE+i)}; pulse `irq_ack[i]`.
- Trap sequence IDLE→MEPC→MSTATUS→MCAUSE→IDLE.
  - MEPC: write 0x341 ← epc.
  - MSTATUS: write 0x300 ← mstatus with bit7 (MPIE) ← bit3, bit3 ← 0.
  - MCAUSE: write 0x342 ← cause; `int_flag`=1.
- Redirect target in MCAUSE:
  - `mtvec[1:0]`=01 and async: `int_addr` = {mtvec[31:2],2'b00} + 4·(CAUSE_BASE+i).
  - Otherwise: {mtvec[31:2],2'b00}.
- mret: IDLE→MRET→IDLE. In MRET: write 0x300 ← mstatus with bit3 ← bit7, bit7 ← 1; `int_flag`=1; `int_addr`=`mepc`.
- All other states/outputs: `csr_we`=0, `csr_waddr`=0, `csr_wdata`=0, `int_flag`=0, `int_addr`=0.
- `set_pl_pause` = (state != IDLE) | (IDLE and any request present). It is combinational so the MEM instruction is frozen in the detecting cycle.
- Requests arriving while not IDLE are ignored. Edge pendings stay latched; level sources must still be asserted to be taken.
- `mstatus` is sampled in the cycle it is written; the stall guarantees no competing EX write.

## Timing
- Reset (`clr`=1 at posedge): state=IDLE, epc=0, cause=0, edge pendings=0.
  - Edge sample register loads the current `irq_pins`, so a pin high at reset release is not an edge.
  - All outputs 0 except `set_pl_pause`, which follows the combinational rule.
- Trap taken from IDLE in cycle T:
  - T+1: MEPC write.
  - T+2: MSTATUS write.
  - T+3: MCAUSE write with `int_flag` and `int_addr`.
  - T+4: IDLE, stall released.
- `irq_ack` pulses in cycle T (combinational, IDLE only).
- mret detected in T: MRET in T+1 (write + redirect); IDLE in T+2.
- A pending async after mret is taken no earlier than T+2, once `mstatus[3]` reflects the restored MIE.
- `clr` mid-sequence: next cycle is IDLE with outputs 0. No partial CSR write completes after the reset edge.
- Back-to-back traps are possible from T+4.

## Test plan
- Level IRQ 2 high, mie=0x4, mstatus=0x8, instr_addr_MEM=0x100, mtvec=0x200 → `irq_ack`=0x04 at T.
  - T+1: csr 0x341←0x100.
  - T+2: 0x300←0x80.
  - T+3: 0x342←0x80000012, int_flag=1, int_addr=0x200.
  - T+4: pause=0.
- Same stimulus with mtvec=0x201 → int_addr=0x200+4·18=0x248.
- Edge source 0 (EDGE_MASK=1), 1-cycle pulse while state=MSTATUS of an ecall trap → the ecall completes with cause 0x0000000B. The pending source is taken only after mret restores MIE=1; mcause=0x80000010.
- ecall with branch_MEM=1, branch_addr_MEM=0x40, simultaneous IRQ 1 → mepc←0x3C, cause 0xB, no `irq_ack`.
- mret with mstatus=0x80, mepc=0x104 → T+1: 0x300←0x88, int_flag=1, int_addr=0x104; T+2: IDLE.
- `clr` asserted in MSTATUS → next cycle all outputs 0 and IDLE. IRQ pin held high through reset with EDGE_MASK=1 → no trap.

Source files
------------

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: picks ecall, mret or the lowest eligible
// interrupt, writes mepc/mstatus/mcause over consecutive cycles and redirects fetch.
module irq_trap_ctrl #(
  parameter int              N_IRQ      = 8,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
  parameter int              CAUSE_BASE = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_IRQ-1:0] irq_pins,
  input  logic             ecall_MEM,
  input  logic             mret_MEM,
  input  logic [31:0]      instr_addr_MEM,
  input  logic             branch_MEM,
  input  logic [31:0]      branch_addr_MEM,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  input  logic [31:0]      mstatus,
  input  logic [31:0]      mie,
  output logic             set_pl_pause,
  output logic             csr_we,
  output logic [11:0]      csr_waddr,
  output logic [31:0]      csr_wdata,
  output logic             int_flag,
  output logic [31:0]      int_addr,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEPC    = 3'd1;
  localparam logic [2:0] S_MSTATUS = 3'd2;
  localparam logic [2:0] S_MCAUSE  = 3'd3;
  localparam logic [2:0] S_MRET    = 3'd4;

  logic [2:0]       r_state;
  logic [31:0]      r_epc;
  logic [31:0]      r_cause;
  logic [N_IRQ-1:0] r_pinSample;
  logic [N_IRQ-1:0] r_edgePend;

  logic [N_IRQ-1:0] w_pending;
  logic [N_IRQ-1:0] w_eligible;
  logic [N_IRQ-1:0] w_winOneHot;
  logic [4:0]       w_winIdx;
  logic [30:0]      w_winCode;
  logic             w_idle;
  logic             w_asyncReq;
  logic             w_takeEcall;
  logic             w_takeMret;
  logic             w_takeAsync;
  logic [31:0]      w_trapBase;
  logic             w_unused;

  assign w_pending   = (r_edgePend & EDGE_MASK) | (irq_pins & ~EDGE_MASK);
  assign w_eligible  = w_pending & mie[N_IRQ-1:0];
  // Two's-complement trick isolates the lowest set bit, which is the winner.
  assign w_winOneHot = w_eligible & (~w_eligible + N_IRQ'(1));
  assign w_asyncReq  = (|w_eligible) & mstatus[3];
  assign w_idle      = (r_state == S_IDLE);
  assign w_takeEcall = w_idle & ecall_MEM;
  assign w_takeMret  = w_idle & ~ecall_MEM & mret_MEM;
  assign w_takeAsync = w_idle & ~ecall_MEM & ~mret_MEM & w_asyncReq;
  assign w_winCode   = 31'(CAUSE_BASE) + 31'(w_winIdx);
  assign w_trapBase  = {mtvec[31:2], 2'b00};
  assign w_unused    = &{1'b0, mie[31:N_IRQ]};

  assign set_pl_pause = ~w_idle | ecall_MEM | mret_MEM | w_asyncReq;
  assign irq_ack      = w_takeAsync ? w_winOneHot : '0;

  always_comb begin
    w_winIdx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winIdx = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_epc       <= '0;
      r_cause     <= '0;
      r_edgePend  <= '0;
      r_pinSample <= irq_pins;
    end else begin
      r_pinSample <= irq_pins;
      // A new rising edge in the ack cycle wins over the clear.
      r_edgePend  <= ((r_edgePend & ~irq_ack) | (irq_pins & ~r_pinSample)) & EDGE_MASK;
      case (r_state)
        S_IDLE: begin
          if (w_takeEcall) begin
            r_state <= S_MEPC;
            r_epc   <= branch_MEM ? (branch_addr_MEM - 32'd4) : instr_addr_MEM;
            r_cause <= 32'h0000_000B;
          end else if (w_takeMret) begin
            r_state <= S_MRET;
          end else if (w_takeAsync) begin
            r_state <= S_MEPC;
            r_epc   <= branch_MEM ? branch_addr_MEM : instr_addr_MEM;
            r_cause <= {1'b1, w_winCode};
          end
        end
        S_MEPC:    r_state <= S_MSTATUS;
        S_MSTATUS: r_state <= S_MCAUSE;
        S_MCAUSE:  r_state <= S_IDLE;
        S_MRET:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = 12'h000;
    csr_wdata = 32'h0;
    int_flag  = 1'b0;
    int_addr  = 32'h0;
    case (r_state)
      S_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = r_epc;
      end
      S_MSTATUS: begin
        csr_we       = 1'b1;
        csr_waddr    = 12'h300;
        csr_wdata    = mstatus;
        csr_wdata[7] = mstatus[3];
        csr_wdata[3] = 1'b0;
      end
      S_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = r_cause;
        int_flag  = 1'b1;
        // Vectored mode only applies to interrupts; cause*4 is the table offset.
        if (mtvec[1:0] == 2'b01 && r_cause[31])
          int_addr = w_trapBase + {r_cause[29:0], 2'b00};
        else
          int_addr = w_trapBase;
      end
      S_MRET: begin
        csr_we       = 1'b1;
        csr_waddr    = 12'h300;
        csr_wdata    = mstatus;
        csr_wdata[3] = mstatus[7];
        csr_wdata[7] = 1'b1;
        int_flag     = 1'b1;
        int_addr     = mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: a per-cycle vector table plus hand-built
// sequences for edge latching across mret and reset in mid-trap.
module tb_irq_trap_ctrl;

  typedef struct {
    logic        clr;
    logic [7:0]  pins;
    logic        ecall;
    logic        mret;
    logic [31:0] instr;
    logic        branch;
    logic [31:0] baddr;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic        expPause;
    logic        expWe;
    logic [11:0] expWaddr;
    logic [31:0] expWdata;
    logic        expFlag;
    logic [31:0] expAddr;
    logic [7:0]  expAck;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  irq_pins;
  logic        ecall_MEM, mret_MEM, branch_MEM;
  logic [31:0] instr_addr_MEM, branch_addr_MEM, mtvec, mepc, mstatus, mie;
  logic        set_pl_pause, csr_we, int_flag;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, int_addr;
  logic [7:0]  irq_ack;

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs[$];
  vec_t v;

  always #5 clk = ~clk;

  irq_trap_ctrl #(.N_IRQ(8), .EDGE_MASK(8'h01), .CAUSE_BASE(16)) dut (
    .clk(clk), .clr(clr), .irq_pins(irq_pins),
    .ecall_MEM(ecall_MEM), .mret_MEM(mret_MEM),
    .instr_addr_MEM(instr_addr_MEM), .branch_MEM(branch_MEM),
    .branch_addr_MEM(branch_addr_MEM),
    .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus), .mie(mie),
    .set_pl_pause(set_pl_pause), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .int_flag(int_flag), .int_addr(int_addr),
    .irq_ack(irq_ack)
  );

  function automatic vec_t row(
    input logic [7:0] pins, input logic ecall, input logic mret,
    input logic [31:0] instr, input logic branch, input logic [31:0] baddr,
    input logic [31:0] tvec, input logic [31:0] epc, input logic [31:0] mst,
    input logic [31:0] ie, input logic pause, input logic we,
    input logic [11:0] waddr, input logic [31:0] wdata, input logic flag,
    input logic [31:0] addr, input logic [7:0] ack);
    vec_t r;
    r.clr = 1'b0;       r.pins = pins;       r.ecall = ecall;   r.mret = mret;
    r.instr = instr;    r.branch = branch;   r.baddr = baddr;   r.mtvec = tvec;
    r.mepc = epc;       r.mstatus = mst;     r.mie = ie;
    r.expPause = pause; r.expWe = we;        r.expWaddr = waddr;
    r.expWdata = wdata; r.expFlag = flag;    r.expAddr = addr;  r.expAck = ack;
    return r;
  endfunction

  function automatic vec_t expectIdle(input vec_t base);
    vec_t r = base;
    r.expPause = 1'b0; r.expWe = 1'b0; r.expWaddr = '0; r.expWdata = '0;
    r.expFlag = 1'b0;  r.expAddr = '0; r.expAck = '0;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    @(posedge clk);
    #1;
    clr = s.clr;              irq_pins = s.pins;
    ecall_MEM = s.ecall;      mret_MEM = s.mret;
    instr_addr_MEM = s.instr; branch_MEM = s.branch;
    branch_addr_MEM = s.baddr;
    mtvec = s.mtvec; mepc = s.mepc; mstatus = s.mstatus; mie = s.mie;
  endtask

  task automatic checkOutput(input string tag, input string field, input int idx,
                             input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s[%0d].%s: got 0x%08h, expected 0x%08h", tag, idx, field, got, exp);
    end
  endtask

  task automatic checkRow(input string tag, input int idx, input vec_t s);
    @(negedge clk);
    checkOutput(tag, "pause", idx, 32'(set_pl_pause), 32'(s.expPause));
    checkOutput(tag, "we",    idx, 32'(csr_we),       32'(s.expWe));
    checkOutput(tag, "waddr", idx, 32'(csr_waddr),    32'(s.expWaddr));
    checkOutput(tag, "wdata", idx, csr_wdata,         s.expWdata);
    checkOutput(tag, "flag",  idx, 32'(int_flag),     32'(s.expFlag));
    checkOutput(tag, "addr",  idx, int_addr,          s.expAddr);
    checkOutput(tag, "ack",   idx, 32'(irq_ack),      32'(s.expAck));
  endtask

  task automatic step(input string tag, input int idx, input vec_t s);
    applyStimulus(s);
    checkRow(tag, idx, s);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clr = 1'b1; irq_pins = '0; ecall_MEM = 0; mret_MEM = 0; branch_MEM = 0;
    instr_addr_MEM = '0; branch_addr_MEM = '0;
    mtvec = '0; mepc = '0; mstatus = '0; mie = '0;

    // Level IRQ2, direct mtvec
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h200,0,32'h08,32'h4, 1,0,12'h000,32'h0,0,32'h0,8'h04));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h200,0,32'h08,32'h4, 1,1,12'h341,32'h100,0,32'h0,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h200,0,32'h08,32'h4, 1,1,12'h300,32'h80,0,32'h0,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h200,0,32'h80,32'h4, 1,1,12'h342,32'h80000012,1,32'h200,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h200,0,32'h80,32'h4, 0,0,12'h000,32'h0,0,32'h0,8'h00));
    // Same with vectored mtvec
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h201,0,32'h08,32'h4, 1,0,12'h000,32'h0,0,32'h0,8'h04));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h201,0,32'h08,32'h4, 1,1,12'h341,32'h100,0,32'h0,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h201,0,32'h08,32'h4, 1,1,12'h300,32'h80,0,32'h0,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h201,0,32'h80,32'h4, 1,1,12'h342,32'h80000012,1,32'h248,8'h00));
    vecs.push_back(row(8'h04,0,0,32'h100,0,0,32'h201,0,32'h80,32'h4, 0,0,12'h000,32'h0,0,32'h0,8'h00));
    // ecall after taken branch beats IRQ1; vectored mtvec ignored for exceptions
    vecs.push_back(row(8'h02,1,0,32'h100,1,32'h40,32'h201,0,32'h08,32'h2, 1,0,12'h000,32'h0,0,32'h0,8'h00));
    vecs.push_back(row(8'h02,1,0,32'h100,1,32'h40,32'h201,0,32'h08,32'h2, 1,1,12'h341,32'h3C,0,32'h0,8'h00));
    vecs.push_back(row(8'h02,1,0,32'h100,1,32'h40,32'h201,0,32'h08,32'h2, 1,1,12'h300,32'h80,0,32'h0,8'h00));
    vecs.push_back(row(8'h02,1,0,32'h100,1,32'h40,32'h201,0,32'h80,32'h2, 1,1,12'h342,32'hB,1,32'h200,8'h00));
    vecs.push_back(row(8'h02,0,0,32'h100,0,0,32'h201,0,32'h80,32'h2, 0,0,12'h000,32'h0,0,32'h0,8'h00));
    // mret restores MIE from MPIE
    vecs.push_back(row(8'h00,0,1,32'h0,0,0,32'h200,32'h104,32'h80,32'h0, 1,0,12'h000,32'h0,0,32'h0,8'h00));
    vecs.push_back(row(8'h00,0,1,32'h0,0,0,32'h200,32'h104,32'h80,32'h0, 1,1,12'h300,32'h88,1,32'h104,8'h00));
    vecs.push_back(row(8'h00,0,0,32'h0,0,0,32'h200,32'h104,32'h88,32'h0, 0,0,12'h000,32'h0,0,32'h0,8'h00));

    repeat (2) @(posedge clk);
    v = expectIdle(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    checkRow("reset", 0, v);
    @(posedge clk);
    #1 clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step("vec", i, vecs[i]);

    // Edge on source 0 during an ecall's MSTATUS write, taken after mret
    v = row(8'h00,1,0,32'h300,0,0,32'h200,0,32'h08,32'h1, 1,0,12'h000,32'h0,0,32'h0,8'h00);
    step("edge", 0, v);
    v.expWe = 1; v.expWaddr = 12'h341; v.expWdata = 32'h300;             step("edge", 1, v);
    v.pins = 8'h01; v.expWaddr = 12'h300; v.expWdata = 32'h80;           step("edge", 2, v);
    v.pins = 8'h00; v.mstatus = 32'h80; v.expWaddr = 12'h342;
    v.expWdata = 32'hB; v.expFlag = 1; v.expAddr = 32'h200;              step("edge", 3, v);
    v.ecall = 0; v = expectIdle(v);                                      step("edge", 4, v);
    step("edge", 5, v);
    v.mret = 1; v.mepc = 32'h300; v.expPause = 1;                        step("edge", 6, v);
    v.expWe = 1; v.expWaddr = 12'h300; v.expWdata = 32'h88;
    v.expFlag = 1; v.expAddr = 32'h300;                                  step("edge", 7, v);
    v.mret = 0; v.mstatus = 32'h88; v = expectIdle(v);
    v.expPause = 1; v.expAck = 8'h01;                                    step("edge", 8, v);
    v.expAck = 0; v.expWe = 1; v.expWaddr = 12'h341; v.expWdata = 32'h300; step("edge", 9, v);
    v.expWaddr = 12'h300; v.expWdata = 32'h80;                           step("edge", 10, v);
    v.mstatus = 32'h80; v.expWaddr = 12'h342; v.expWdata = 32'h80000010;
    v.expFlag = 1; v.expAddr = 32'h200;                                  step("edge", 11, v);
    v.mstatus = 32'h88; v = expectIdle(v);                               step("edge", 12, v);

    // Reset while in MSTATUS aborts the sequence
    v = row(8'h04,0,0,32'h120,0,0,32'h200,0,32'h08,32'h4, 1,0,12'h000,32'h0,0,32'h0,8'h04);
    step("clr", 0, v);
    v.expAck = 0; v.expWe = 1; v.expWaddr = 12'h341; v.expWdata = 32'h120; step("clr", 1, v);
    v.clr = 1; v.expWaddr = 12'h300; v.expWdata = 32'h80;                step("clr", 2, v);
    v.clr = 0; v.pins = 8'h00; v = expectIdle(v);                        step("clr", 3, v);
    step("clr", 4, v);

    // Edge pin already high across reset must not be seen as an edge
    v = expectIdle(row(8'h01,0,0,32'h140,0,0,32'h200,0,32'h08,32'h1, 0,0,0,0,0,0,0));
    v.clr = 1;                                                           step("hold", 0, v);
    v.clr = 0;
    for (int i = 1; i < 4; i++) step("hold", i, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
